// File: rtl/tdc_sample_acc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tdc_sample_acc
//
// Post-processing stage for the TDC core. It collects a run of 2^LOG2_N valid
// 8-bit samples and produces three statistics: the truncated mean, the
// minimum and the maximum. Results are held in result registers so they stay
// readable while the next run is in progress. A registered byte-wide mux
// presents one result (or a status byte) to the output pins.
//
// Parameters
//   LOG2_N        log2 of samples per run (legal 1..8)
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   sample_in     TDC output word, synchronous to clk
//   sample_valid  sample_in is valid this cycle
//   start         pulse that begins a run (ignored while a run is active)
//   abort         terminates an active run, discarding partial data
//   rd_sel        0 mean, 1 min, 2 max, 3 status {busy, done, run_cnt[5:0]}
//   rd_data       registered selected result
//   busy          a run is in progress
//   done          a run has completed and no new run has started since
// -----------------------------------------------------------------------------
module tdc_sample_acc #(
  parameter int LOG2_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);

  localparam int N  = 1 << LOG2_N;
  // Sum of N 8-bit values needs LOG2_N extra bits; it can never overflow.
  localparam int SW = LOG2_N + 8;
  // Counter must be able to hold the value N itself.
  localparam int CW = LOG2_N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q,    state_d;
  logic [SW-1:0] sum_q,      sum_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [7:0]    acc_min_q,  acc_min_d;
  logic [7:0]    acc_max_q,  acc_max_d;
  logic [7:0]    res_mean_q, res_mean_d;
  logic [7:0]    res_min_q,  res_min_d;
  logic [7:0]    res_max_q,  res_max_d;
  logic [5:0]    run_cnt_q,  run_cnt_d;
  logic [7:0]    rd_data_q,  rd_data_d;

  logic          run_full;
  logic          busy_w;
  logic          done_w;

  // The last sample of a run is accumulated on its own edge; the results are
  // committed on the following edge from the accumulators. This gives the
  // 1 + 2^LOG2_N cycle start-to-done latency for a back-to-back run.
  assign run_full = (cnt_q == CW'(N));

  assign busy_w = (state_q == ACQ);
  assign done_w = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      cnt_q      <= '0;
      acc_min_q  <= 8'hFF;
      acc_max_q  <= 8'h00;
      res_mean_q <= 8'h00;
      res_min_q  <= 8'h00;
      res_max_q  <= 8'h00;
      run_cnt_q  <= 6'd0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      acc_min_q  <= acc_min_d;
      acc_max_q  <= acc_max_d;
      res_mean_q <= res_mean_d;
      res_min_q  <= res_min_d;
      res_max_q  <= res_max_d;
      run_cnt_q  <= run_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    acc_min_d  = acc_min_q;
    acc_max_d  = acc_max_q;
    res_mean_d = res_mean_q;
    res_min_d  = res_min_q;
    res_max_d  = res_max_q;
    run_cnt_d  = run_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        // A sample arriving together with start is deliberately not taken.
        if (start) begin
          state_d   = ACQ;
          sum_d     = '0;
          cnt_d     = '0;
          acc_min_d = 8'hFF;
          acc_max_d = 8'h00;
        end
      end

      ACQ: begin
        // abort beats both sample acceptance and result commit; start is
        // ignored here so a run cannot be restarted part-way.
        if (abort) begin
          state_d = IDLE;
        end else if (run_full) begin
          res_mean_d = sum_q[SW-1:LOG2_N];
          res_min_d  = acc_min_q;
          res_max_d  = acc_max_q;
          run_cnt_d  = run_cnt_q + 6'd1;
          state_d    = DONE;
        end else if (sample_valid) begin
          sum_d = sum_q + SW'(sample_in);
          cnt_d = cnt_q + CW'(1);
          if (sample_in < acc_min_q) begin
            acc_min_d = sample_in;
          end
          if (sample_in > acc_max_q) begin
            acc_max_d = sample_in;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read mux, registered one cycle behind rd_sel
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_d = 8'h00;
    case (rd_sel)
      2'd0: rd_data_d = res_mean_q;
      2'd1: rd_data_d = res_min_q;
      2'd2: rd_data_d = res_max_q;
      2'd3: rd_data_d = {busy_w, done_w, run_cnt_q};
    endcase
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_w;
  assign done    = done_w;

endmodule

// File: tb/tb_tdc_sample_acc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// Bench for tdc_sample_acc (LOG2_N = 4). A queue-based model collects the
// samples of each run and computes mean/min/max with plain arithmetic when the
// run completes; a compare process checks rd_data/busy/done against it every
// cycle. Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_tdc_sample_acc;

  localparam int LOG2_N = 4;
  localparam int N      = 1 << LOG2_N;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] rd_sel = 2'd0;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  tdc_sample_acc #(.LOG2_N(LOG2_N)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .start        (start),
    .abort        (abort),
    .rd_sel       (rd_sel),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [7:0] m_mean = 0, m_min = 0, m_max = 0, m_rd = 0;
  logic       m_busy = 0, m_done = 0;
  int         m_runs = 0;
  logic [7:0] q[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mean = 0; m_min = 0; m_max = 0; m_rd = 0;
        m_busy = 0; m_done = 0; m_runs = 0;
        q.delete();
      end else begin
        // Read port shows the values held before this edge.
        case (rd_sel)
          2'd0: m_rd = m_mean;
          2'd1: m_rd = m_min;
          2'd2: m_rd = m_max;
          default: m_rd = {m_busy, m_done, 6'(m_runs)};
        endcase
        if (m_busy && q.size() == N) begin
          if (abort) begin
            m_busy = 0;
          end else begin
            int s;
            int mn;
            int mx;
            s = 0; mn = 255; mx = 0;
            foreach (q[i]) begin
              s += q[i];
              if (q[i] < mn) mn = q[i];
              if (q[i] > mx) mx = q[i];
            end
            m_mean = 8'(s / N);
            m_min  = 8'(mn);
            m_max  = 8'(mx);
            m_runs = (m_runs + 1) % 64;
            m_busy = 0;
            m_done = 1;
          end
        end else if (m_busy) begin
          if (abort) m_busy = 0;
          else if (sample_valid) q.push_back(sample_in);
        end else if (start) begin
          m_busy = 1;
          m_done = 0;
          q.delete();
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data", {24'd0, rd_data}, {24'd0, m_rd});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic a);
    start = s; sample_valid = v; sample_in = d; abort = a;
    @(negedge clk);
  endtask

  task automatic read(input logic [1:0] sel, input logic [7:0] exp, input string name);
    step(0, 0, 8'h00, 0);
    rd_sel = sel;
    @(negedge clk);
    check(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_rd_data", {24'd0, rd_data}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    check("reset_done", {31'd0, done}, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // abort while idle is ignored
    step(0, 0, 8'h00, 1);

    // Run 1: samples 0..15, start carries a valid sample that must be skipped
    step(1, 1, 8'd200, 0);
    for (int i = 0; i < N; i++) step(0, 1, 8'(i), 0);
    check("run1_done_not_yet", {31'd0, done}, 32'h0);
    step(0, 0, 8'h00, 0);
    check("run1_done_next", {31'd0, done}, 32'h1);
    check("model_mean_pin", {24'd0, m_mean}, 32'd7);
    read(2'd0, 8'd7,  "run1_mean");
    read(2'd1, 8'd0,  "run1_min");
    read(2'd2, 8'd15, "run1_max");
    read(2'd3, 8'h41, "run1_status");

    // Run 2: all 8'hFF with random gaps; start+abort together in DONE -> start
    step(1, 0, 8'h00, 1);
    check("start_beats_abort", {31'd0, busy}, 32'h1);
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step(0, 0, 8'($urandom_range(0, 255)), 0);
      step(0, 1, 8'hFF, 0);
    end
    step(0, 0, 8'h00, 0);
    read(2'd0, 8'd255, "run2_mean");
    read(2'd1, 8'd255, "run2_min");
    read(2'd2, 8'd255, "run2_max");
    read(2'd3, 8'h42,  "run2_status");

    // Partial run aborted after 5 samples: previous results remain
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'd1, 0);
    step(0, 1, 8'd1, 1);  // abort beats a coincident sample
    check("abort_busy", {31'd0, busy}, 32'h0);
    check("abort_done", {31'd0, done}, 32'h0);
    read(2'd0, 8'd255, "abort_mean");
    read(2'd1, 8'd255, "abort_min");
    read(2'd3, 8'h02,  "abort_status");

    // start mid-run is ignored; stats cover all 16 samples
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'(10 * i + 3), 0);
    step(1, 0, 8'h00, 0);
    for (int i = 8; i < N; i++) step(0, 1, 8'(10 * i + 3), 0);
    check("restart_done_not_yet", {31'd0, done}, 32'h0);
    step(0, 0, 8'h00, 0);
    check("restart_done", {31'd0, done}, 32'h1);
    read(2'd0, 8'd78,  "restart_mean");
    read(2'd1, 8'd3,   "restart_min");
    read(2'd2, 8'd153, "restart_max");
    read(2'd3, 8'h43,  "restart_status");

    // abort in DONE is ignored
    step(0, 0, 8'h00, 1);
    check("abort_in_done", {31'd0, done}, 32'h1);

    // Asynchronous reset mid-run, between clock edges
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'd50, 0);
    start = 0; sample_valid = 0; abort = 0; rd_sel = 2'd3;
    #2 rst = 1'b1;
    #1;
    check("async_rst_rd_data", {24'd0, rd_data}, 32'h0);
    check("async_rst_busy", {31'd0, busy}, 32'h0);
    check("async_rst_done", {31'd0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < N; i++) step(0, 1, 8'(16 + i), 0);
    step(0, 0, 8'h00, 0);
    read(2'd0, 8'd23,  "post_rst_mean");
    read(2'd1, 8'd16,  "post_rst_min");
    read(2'd2, 8'd31,  "post_rst_max");
    read(2'd3, 8'h41,  "post_rst_status");

    // 63 more completed runs: run_cnt wraps from 63 to 0
    for (int r = 0; r < 63; r++) begin
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < N; i++) step(0, 1, 8'd5, 0);
      step(0, 0, 8'h00, 0);
    end
    read(2'd3, 8'h40, "wrap_status");
    read(2'd0, 8'd5,  "wrap_mean");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
